// File: rtl/alu_accumulator.sv
// ---------------------------------------------------------------------------
// alu_accumulator
//
// Registered accumulator ALU. Two accumulators (AccA, AccB) are loaded from
// din while idle; a start strobe runs one of eight opcodes on them and writes
// the result back into AccA together with registered carry/zero/overflow
// flags. Shift-left moves one bit per clock, so shifts of two or more
// positions run as a short multi-cycle command.
//
// Parameters:
//   WIDTH  operand / accumulator width (>= 2)
//   SHW    width of the shift-amount field taken from AccB[SHW-1:0]
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-high reset, clears all state
//   din    load data for the accumulators
//   ld_a   load din into AccA (idle only)
//   ld_b   load din into AccB (idle only)
//   op     opcode, sampled together with start
//   start  command strobe (idle only)
//   busy   multi-cycle shift in progress; commands and loads are ignored
//   done   one-cycle pulse when result and flags are valid
//   acc_a  AccA contents (result)
//   acc_b  AccB contents
//   carry  registered carry flag
//   zero   registered zero flag (AccA == 0 after the op)
//   ovf    registered signed-overflow flag
// ---------------------------------------------------------------------------
module alu_accumulator #(
    parameter int WIDTH = 4,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             ld_a,
    input  logic             ld_b,
    input  logic [2:0]       op,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] acc_a,
    output logic [WIDTH-1:0] acc_b,
    output logic             carry,
    output logic             zero,
    output logic             ovf
);

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_NOT = 3'b001;
    localparam logic [2:0] OP_OR  = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_SHL = 3'b100;
    localparam logic [2:0] OP_ADD = 3'b101;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_NEG = 3'b111;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    logic [0:0]       state;
    logic [SHW-1:0]   count;
    logic [WIDTH-1:0] reg_a;
    logic [WIDTH-1:0] reg_b;
    logic             reg_carry;
    logic             reg_zero;
    logic             reg_ovf;
    logic             reg_done;

    logic [SHW-1:0]   shift_amt;
    logic [WIDTH-1:0] shl1;
    logic [WIDTH-1:0] add_x;
    logic [WIDTH-1:0] add_y;
    logic             add_cin;
    logic [WIDTH-1:0] add_sum;
    logic             add_co;
    logic             add_ovf;
    logic [WIDTH-1:0] res;
    logic             res_c;
    logic             res_v;

    assign shift_amt = reg_b[SHW-1:0];
    assign shl1      = {reg_a[WIDTH-2:0], 1'b0};

    // One shared adder serves ADD, SUB and NEG. SUB feeds ~B with a carry-in
    // and NEG feeds ~A + 0 with a carry-in, so the usual same-sign-in /
    // different-sign-out overflow rule yields the NEG overflow (A = 100..0)
    // and the NEG carry (A = 0) without extra logic.
    always_comb begin
        add_x   = reg_a;
        add_y   = reg_b;
        add_cin = 1'b0;
        if (op == OP_SUB) begin
            add_y   = ~reg_b;
            add_cin = 1'b1;
        end else if (op == OP_NEG) begin
            add_x   = ~reg_a;
            add_y   = '0;
            add_cin = 1'b1;
        end
        {add_co, add_sum} = {1'b0, add_x} + {1'b0, add_y} + {{WIDTH{1'b0}}, add_cin};
        add_ovf = (add_x[WIDTH-1] == add_y[WIDTH-1]) && (add_sum[WIDTH-1] != add_x[WIDTH-1]);
    end

    // Single-cycle result selection. SHL here covers only k = 0 and k = 1;
    // longer shifts are handled by the SHIFT state.
    always_comb begin
        res   = reg_a;
        res_c = 1'b0;
        res_v = 1'b0;
        case (op)
            OP_AND: res = reg_a & reg_b;
            OP_NOT: res = ~reg_a;
            OP_OR:  res = reg_a | reg_b;
            OP_XOR: res = reg_a ^ reg_b;
            OP_SHL: begin
                if (shift_amt != '0) begin
                    res   = shl1;
                    res_c = reg_a[WIDTH-1];
                end
            end
            OP_ADD, OP_SUB, OP_NEG: begin
                res   = add_sum;
                res_c = add_co;
                res_v = add_ovf;
            end
            default: res = reg_a;
        endcase
    end

    // Command FSM and register file. In IDLE a start wins over loads, and
    // the op always sees the pre-edge accumulators. A shift of k >= 2 does
    // its first step on the start edge and leaves k-1 steps in the counter;
    // flags are only written when the last step lands.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            count     <= '0;
            reg_a     <= '0;
            reg_b     <= '0;
            reg_carry <= 1'b0;
            reg_zero  <= 1'b0;
            reg_ovf   <= 1'b0;
            reg_done  <= 1'b0;
        end else begin
            reg_done <= 1'b0;
            if (state == ST_IDLE) begin
                if (start) begin
                    if ((op == OP_SHL) && (shift_amt > SHW'(1))) begin
                        reg_a <= shl1;
                        count <= shift_amt - SHW'(1);
                        state <= ST_SHIFT;
                    end else begin
                        reg_a     <= res;
                        reg_carry <= res_c;
                        reg_zero  <= (res == '0);
                        reg_ovf   <= res_v;
                        reg_done  <= 1'b1;
                    end
                end else begin
                    if (ld_a) begin
                        reg_a <= din;
                    end
                    if (ld_b) begin
                        reg_b <= din;
                    end
                end
            end else begin
                reg_a <= shl1;
                count <= count - SHW'(1);
                if (count == SHW'(1)) begin
                    state     <= ST_IDLE;
                    reg_carry <= reg_a[WIDTH-1];
                    reg_zero  <= (shl1 == '0);
                    reg_ovf   <= 1'b0;
                    reg_done  <= 1'b1;
                end
            end
        end
    end

    assign busy  = (state == ST_SHIFT);
    assign done  = reg_done;
    assign acc_a = reg_a;
    assign acc_b = reg_b;
    assign carry = reg_carry;
    assign zero  = reg_zero;
    assign ovf   = reg_ovf;

endmodule

// File: tb/tb_alu_accumulator.sv
// ---------------------------------------------------------------------------
// tb_alu_accumulator
//
// Self-checking bench for alu_accumulator at WIDTH = 4. A table of
// {operation, operands, expected result/flags} records is applied in a loop,
// followed by hand-written sequences for the multi-cycle shift, load/start
// priority, back-to-back commands and reset during a shift.
// ---------------------------------------------------------------------------
module tb_alu_accumulator;

    localparam int W = 4;

    logic         clk;
    logic         reset;
    logic [W-1:0] din;
    logic         ld_a;
    logic         ld_b;
    logic [2:0]   op;
    logic         start;
    logic         busy;
    logic         done;
    logic [W-1:0] acc_a;
    logic [W-1:0] acc_b;
    logic         carry;
    logic         zero;
    logic         ovf;

    int checks;
    int errors;

    typedef struct {
        string      name;
        logic [2:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] exp_a;
        logic       exp_c;
        logic       exp_z;
        logic       exp_v;
    } vec_t;

    vec_t vecs[15];

    alu_accumulator #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .din   (din),
        .ld_a  (ld_a),
        .ld_b  (ld_b),
        .op    (op),
        .start (start),
        .busy  (busy),
        .done  (done),
        .acc_a (acc_a),
        .acc_b (acc_b),
        .carry (carry),
        .zero  (zero),
        .ovf   (ovf)
    );

    // Free-running clock, 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge, where inputs are changed
    // and registered outputs are sampled.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compare one value and record the outcome.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Load AccB then AccA through the idle load path.
    task automatic loadAB(input logic [3:0] a, input logic [3:0] b);
        ld_b = 1'b1; din = b; tick();
        ld_b = 1'b0;
        ld_a = 1'b1; din = a; tick();
        ld_a = 1'b0; din = '0;
    endtask

    // Load operands, issue one command and check the single-cycle result.
    task automatic applyStimulus(input vec_t v);
        loadAB(v.a, v.b);
        op = v.op; start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput({v.name, " acc_a"}, 32'(acc_a), 32'(v.exp_a));
        checkOutput({v.name, " carry"}, 32'(carry), 32'(v.exp_c));
        checkOutput({v.name, " zero"},  32'(zero),  32'(v.exp_z));
        checkOutput({v.name, " ovf"},   32'(ovf),   32'(v.exp_v));
        checkOutput({v.name, " done"},  32'(done),  32'(1));
        checkOutput({v.name, " busy"},  32'(busy),  32'(0));
        checkOutput({v.name, " acc_b"}, 32'(acc_b), 32'(v.b));
        tick();
        checkOutput({v.name, " done drop"}, 32'(done), 32'(0));
    endtask

    initial begin
        checks = 0;
        errors = 0;

        vecs[0]  = '{"AND",       3'b000, 4'b0111, 4'b1110, 4'b0110, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{"NOT",       3'b001, 4'b0111, 4'b1110, 4'b1000, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{"OR",        3'b010, 4'b0111, 4'b1110, 4'b1111, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{"XOR",       3'b011, 4'b0111, 4'b1110, 4'b1001, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{"ADD",       3'b101, 4'b0111, 4'b1110, 4'b0101, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{"SUB",       3'b110, 4'b0111, 4'b1110, 4'b1001, 1'b0, 1'b0, 1'b1};
        vecs[6]  = '{"NEG",       3'b111, 4'b0111, 4'b1110, 4'b1001, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{"SHL k0",    3'b100, 4'b0111, 4'b0000, 4'b0111, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{"SHL k1",    3'b100, 4'b0111, 4'b0001, 4'b1110, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{"SHL k1 out",3'b100, 4'b1000, 4'b0101, 4'b0000, 1'b1, 1'b1, 1'b0};
        vecs[10] = '{"NEG zero",  3'b111, 4'b0000, 4'b1110, 4'b0000, 1'b1, 1'b1, 1'b0};
        vecs[11] = '{"NEG min",   3'b111, 4'b1000, 4'b1110, 4'b1000, 1'b0, 1'b0, 1'b1};
        vecs[12] = '{"ADD ovf",   3'b101, 4'b0111, 4'b0001, 4'b1000, 1'b0, 1'b0, 1'b1};
        vecs[13] = '{"SUB nobrw", 3'b110, 4'b0111, 4'b0011, 4'b0100, 1'b1, 1'b0, 1'b0};
        vecs[14] = '{"SUB equal", 3'b110, 4'b0101, 4'b0101, 4'b0000, 1'b1, 1'b1, 1'b0};

        reset = 1'b1;
        din   = '0;
        ld_a  = 1'b0;
        ld_b  = 1'b0;
        op    = 3'b000;
        start = 1'b0;
        tick();
        tick();
        checkOutput("reset acc_a", 32'(acc_a), 32'(0));
        checkOutput("reset acc_b", 32'(acc_b), 32'(0));
        checkOutput("reset flags", 32'({carry, zero, ovf}), 32'(0));
        checkOutput("reset busy",  32'(busy), 32'(0));
        checkOutput("reset done",  32'(done), 32'(0));
        reset = 1'b0;
        tick();

        for (int i = 0; i < 15; i++) begin
            applyStimulus(vecs[i]);
        end

        // Simultaneous ld_a and ld_b both take din.
        ld_a = 1'b1; ld_b = 1'b1; din = 4'b0101;
        tick();
        ld_a = 1'b0; ld_b = 1'b0; din = '0;
        checkOutput("dual load acc_a", 32'(acc_a), 32'(4'b0101));
        checkOutput("dual load acc_b", 32'(acc_b), 32'(4'b0101));

        // SHL k=2 with start/loads asserted while busy.
        loadAB(4'b0111, 4'b1110);
        op = 3'b100; start = 1'b1;
        tick();
        checkOutput("shl2 step1 acc_a", 32'(acc_a), 32'(4'b1110));
        checkOutput("shl2 step1 busy",  32'(busy),  32'(1));
        checkOutput("shl2 step1 done",  32'(done),  32'(0));
        op = 3'b000; start = 1'b1; ld_a = 1'b1; ld_b = 1'b1; din = 4'b1010;
        tick();
        start = 1'b0; ld_a = 1'b0; ld_b = 1'b0; din = '0;
        checkOutput("shl2 final acc_a", 32'(acc_a), 32'(4'b1100));
        checkOutput("shl2 final busy",  32'(busy),  32'(0));
        checkOutput("shl2 final done",  32'(done),  32'(1));
        checkOutput("shl2 carry",       32'(carry), 32'(1));
        checkOutput("shl2 zero",        32'(zero),  32'(0));
        checkOutput("shl2 ovf",         32'(ovf),   32'(0));
        checkOutput("shl2 acc_b kept",  32'(acc_b), 32'(4'b1110));
        tick();
        checkOutput("shl2 done drop",   32'(done),  32'(0));
        checkOutput("shl2 ignored cmd", 32'(acc_a), 32'(4'b1100));

        // start beats ld_a: AND must use the old AccA.
        loadAB(4'b0111, 4'b1110);
        op = 3'b000; start = 1'b1; ld_a = 1'b1; din = 4'b0011;
        tick();
        start = 1'b0; ld_a = 1'b0; din = '0;
        checkOutput("start vs ld_a acc_a", 32'(acc_a), 32'(4'b0110));
        checkOutput("start vs ld_a done",  32'(done),  32'(1));

        // Back-to-back NOT commands on consecutive cycles.
        loadAB(4'b0111, 4'b1110);
        op = 3'b001; start = 1'b1;
        tick();
        checkOutput("b2b first acc_a", 32'(acc_a), 32'(4'b1000));
        checkOutput("b2b first done",  32'(done),  32'(1));
        tick();
        start = 1'b0;
        checkOutput("b2b second acc_a", 32'(acc_a), 32'(4'b0111));
        checkOutput("b2b second done",  32'(done),  32'(1));

        // Reset after the first step of a k=3 shift aborts without done.
        loadAB(4'b0001, 4'b0011);
        op = 3'b100; start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("rst shift step1 acc_a", 32'(acc_a), 32'(4'b0010));
        checkOutput("rst shift step1 busy",  32'(busy),  32'(1));
        reset = 1'b1;
        #1;
        checkOutput("rst abort acc_a", 32'(acc_a), 32'(0));
        checkOutput("rst abort acc_b", 32'(acc_b), 32'(0));
        checkOutput("rst abort busy",  32'(busy),  32'(0));
        checkOutput("rst abort flags", 32'({carry, zero, ovf}), 32'(0));
        tick();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("rst no done", 32'(done), 32'(0));
            checkOutput("rst no busy", 32'(busy), 32'(0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
